// File: rtl/axi_core_master_if.sv
// AXI4 bus bundle shared by initiators and responders.
// Master modport drives AW/W/AR payloads and valids plus the B/R readys;
// Slave modport is the mirror image.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_core_master.sv
// Single-outstanding AXI4 initiator: turns the core's req/gnt/rvalid data
// port into single-beat AXI4 reads and writes.
// Ports: clk_i/rst_ni (async active-low), core side req_i/gnt_o/addr_i/we_i/
// be_i/wdata_i/rvalid_o/rdata_o/err_o, and the AXI_Master bus port.
module axi_core_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  AXI_BUS.Master      AXI_Master
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]                be_q;
  logic [31:0]               wdata_q;
  logic                      aw_valid_q;
  logic                      w_valid_q;
  logic                      ar_valid_q;
  logic                      b_ready_q;
  logic                      r_ready_q;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      ar_hs;

  // Only IDLE grants, so a held request waits out the current transaction.
  assign gnt_o = req_i && (state == IDLE);

  assign aw_hs = aw_valid_q && AXI_Master.aw_ready;
  assign w_hs  = w_valid_q  && AXI_Master.w_ready;
  assign ar_hs = ar_valid_q && AXI_Master.ar_ready;

  // Transaction FSM; the valid registers double as the AW/W pending flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_o   <= 1'b0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            addr_q  <= AXI_ADDR_WIDTH'(addr_i);
            be_q    <= be_i;
            wdata_q <= wdata_i;
            if (we_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state      <= WR_REQ;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_valid_q <= 1'b0;
          if (w_hs)  w_valid_q  <= 1'b0;
          // Leave once neither channel is still waiting for its handshake.
          if ((aw_hs || !aw_valid_q) && (w_hs || !w_valid_q)) begin
            b_ready_q <= 1'b1;
            state     <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (AXI_Master.b_valid) begin
            b_ready_q <= 1'b0;
            err_o     <= AXI_Master.b_resp[1];
            rvalid_o  <= 1'b1;
            state     <= IDLE;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (AXI_Master.r_valid) begin
            r_ready_q <= 1'b0;
            rdata_o   <= 32'(AXI_Master.r_data);
            err_o     <= AXI_Master.r_resp[1];
            rvalid_o  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write address channel: single-beat 32-bit INCR.
  assign AXI_Master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign AXI_Master.aw_addr   = addr_q;
  assign AXI_Master.aw_len    = 8'd0;
  assign AXI_Master.aw_size   = 3'b010;
  assign AXI_Master.aw_burst  = 2'b01;
  assign AXI_Master.aw_lock   = 1'b0;
  assign AXI_Master.aw_cache  = 4'd0;
  assign AXI_Master.aw_prot   = 3'd0;
  assign AXI_Master.aw_qos    = 4'd0;
  assign AXI_Master.aw_region = 4'd0;
  assign AXI_Master.aw_atop   = 6'd0;
  assign AXI_Master.aw_user   = AXI_USER_WIDTH'(0);
  assign AXI_Master.aw_valid  = aw_valid_q;

  // Write data channel.
  assign AXI_Master.w_data  = AXI_DATA_WIDTH'(wdata_q);
  assign AXI_Master.w_strb  = STRB_W'(be_q);
  assign AXI_Master.w_last  = 1'b1;
  assign AXI_Master.w_user  = AXI_USER_WIDTH'(0);
  assign AXI_Master.w_valid = w_valid_q;

  assign AXI_Master.b_ready = b_ready_q;

  // Read address channel.
  assign AXI_Master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign AXI_Master.ar_addr   = addr_q;
  assign AXI_Master.ar_len    = 8'd0;
  assign AXI_Master.ar_size   = 3'b010;
  assign AXI_Master.ar_burst  = 2'b01;
  assign AXI_Master.ar_lock   = 1'b0;
  assign AXI_Master.ar_cache  = 4'd0;
  assign AXI_Master.ar_prot   = 3'd0;
  assign AXI_Master.ar_qos    = 4'd0;
  assign AXI_Master.ar_region = 4'd0;
  assign AXI_Master.ar_user   = AXI_USER_WIDTH'(0);
  assign AXI_Master.ar_valid  = ar_valid_q;

  assign AXI_Master.r_ready = r_ready_q;
endmodule

// File: tb/tb_axi_core_master.sv
// Bench for axi_core_master: a configurable AXI responder, directed core
// requests, and a scoreboard popped by an rvalid_o monitor.
module tb_axi_core_master;
  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16),
            .AXI_USER_WIDTH(10)) axi ();

  axi_core_master #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16),
    .AXI_USER_WIDTH(10), .AXI_ID(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .AXI_Master(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- responder model ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  int          aw_wait, w_wait, ar_wait;
  logic        aw_got, w_got, b_pend, r_pend;
  logic        stray_b = 1'b0, stray_r = 1'b0;
  logic [1:0]  b_resp_v = 2'b00, r_resp_v = 2'b00;
  logic [31:0] rd_val = 32'h0;
  logic        aw_done, w_done;

  assign axi.aw_ready = axi.aw_valid && (aw_wait >= aw_delay);
  assign axi.w_ready  = axi.w_valid  && (w_wait  >= w_delay);
  assign axi.ar_ready = axi.ar_valid && (ar_wait >= ar_delay);
  assign axi.b_valid  = b_pend | stray_b;
  assign axi.b_resp   = b_resp_v;
  assign axi.b_id     = '0;
  assign axi.b_user   = '0;
  assign axi.r_valid  = r_pend | stray_r;
  assign axi.r_data   = rd_val;
  assign axi.r_resp   = r_resp_v;
  assign axi.r_last   = 1'b1;
  assign axi.r_id     = '0;
  assign axi.r_user   = '0;

  assign aw_done = aw_got || (axi.aw_valid && axi.aw_ready);
  assign w_done  = w_got  || (axi.w_valid  && axi.w_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      if (axi.aw_valid && axi.aw_ready) aw_wait <= 0;
      else if (axi.aw_valid)            aw_wait <= aw_wait + 1;
      if (axi.w_valid && axi.w_ready)   w_wait <= 0;
      else if (axi.w_valid)             w_wait <= w_wait + 1;
      if (aw_done && w_done && !b_pend) begin
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_done; w_got <= w_done;
      end
      if (b_pend && axi.b_ready) b_pend <= 1'b0;
      if (axi.ar_valid && axi.ar_ready) begin
        ar_wait <= 0; r_pend <= 1'b1;
      end else if (axi.ar_valid) ar_wait <= ar_wait + 1;
      if (r_pend && axi.r_ready) r_pend <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          gcyc;
  } exp_t;
  exp_t sb[$];

  int   b_hs    = 0;
  logic prev_rv = 1'b0;

  // Monitor: pops one expectation per rvalid_o pulse.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (axi.b_valid && axi.b_ready) b_hs++;
      if (rvalid_o) begin
        check("rvalid_width", 32'(prev_rv), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_rvalid", 32'(rvalid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rdata", rdata_o, e.rdata);
          check("err", 32'(err_o), 32'(e.err));
          check("latency", 32'(cyc - e.gcyc), 32'(e.lat));
          if (e.we) check("b_count", 32'(b_hs), 32'd1);
          b_hs = 0;
        end
      end
      prev_rv = rvalid_o;
    end else begin
      prev_rv = 1'b0;
      b_hs    = 0;
    end
  end

  // Drive a request at a falling edge, wait for its grant, log the expectation.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                        input int elat, input bit chk_rv);
    exp_t e;
    int   n;
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = wd;
    #1;
    n = 0;
    while (!gnt_o && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!gnt_o) begin
      check("grant_timeout", 32'(gnt_o), 32'd1);
    end else begin
      e.we = we; e.rdata = erd; e.err = eerr; e.lat = elat; e.gcyc = cyc;
      sb.push_back(e);
      if (chk_rv) check("b2b_gnt_with_rvalid", 32'(rvalid_o), 32'd1);
    end
    @(posedge clk);
  endtask

  task automatic drop_req();
    @(negedge clk);
    #1;
    req_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); #3; n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_valids", 32'({axi.aw_valid, axi.w_valid, axi.ar_valid}), 32'd0);
    check("rst_readys", 32'({axi.b_ready, axi.r_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_no_gnt", 32'(gnt_o), 32'd0);

    // 1: write with always-ready responder
    do_req(1'b1, 32'h0000_0100, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b0);
    drop_req();
    check("t1_aw_valid", 32'(axi.aw_valid), 32'd1);
    check("t1_w_valid", 32'(axi.w_valid), 32'd1);
    check("t1_w_strb", 32'(axi.w_strb), 32'hF);
    check("t1_w_last", 32'(axi.w_last), 32'd1);
    check("t1_w_data", axi.w_data, 32'hDEADBEEF);
    check("t1_aw_addr", axi.aw_addr, 32'h0000_0100);
    check("t1_aw_size", 32'(axi.aw_size), 32'd2);
    check("t1_aw_burst", 32'(axi.aw_burst), 32'd1);
    check("t1_aw_len", 32'(axi.aw_len), 32'd0);
    wait_done();

    // 2: read back
    rd_val = 32'hDEADBEEF;
    do_req(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
    drop_req();
    check("t2_ar_valid", 32'(axi.ar_valid), 32'd1);
    check("t2_ar_addr", axi.ar_addr, 32'h0000_0100);
    wait_done();

    // 3A: aw_ready 3 cycles late
    aw_delay = 3; w_delay = 0;
    do_req(1'b1, 32'h0000_0104, 4'hF, 32'h1111_2222, 32'hDEADBEEF, 1'b0, 6, 1'b0);
    drop_req();
    @(negedge clk); #1;
    check("t3a_w_dropped", 32'(axi.w_valid), 32'd0);
    check("t3a_aw_held", 32'(axi.aw_valid), 32'd1);
    wait_done();

    // 3B: w_ready 3 cycles late
    aw_delay = 0; w_delay = 3;
    do_req(1'b1, 32'h0000_0108, 4'h5, 32'h3333_4444, 32'hDEADBEEF, 1'b0, 6, 1'b0);
    drop_req();
    @(negedge clk); #1;
    check("t3b_aw_dropped", 32'(axi.aw_valid), 32'd0);
    check("t3b_w_held", 32'(axi.w_valid), 32'd1);
    check("t3b_w_strb", 32'(axi.w_strb), 32'h5);
    wait_done();
    w_delay = 0;

    // 4: DECERR read, then SLVERR write
    rd_val = 32'h0BAD_0BAD; r_resp_v = 2'b11;
    do_req(1'b0, 32'h3000_0000, 4'hF, 32'h0, 32'h0BAD_0BAD, 1'b1, 3, 1'b0);
    drop_req();
    wait_done();
    r_resp_v = 2'b00; b_resp_v = 2'b10;
    do_req(1'b1, 32'h3000_0004, 4'hF, 32'h5555_6666, 32'h0BAD_0BAD, 1'b1, 3, 1'b0);
    drop_req();
    wait_done();
    b_resp_v = 2'b00;

    // 5: held request across read then write
    rd_val = 32'h1234_5678;
    do_req(1'b0, 32'h0000_0200, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b0);
    @(negedge clk); #1;
    check("t5_held_no_gnt", 32'(gnt_o), 32'd0);
    do_req(1'b1, 32'h0000_0204, 4'h3, 32'hA5A5_A5A5, 32'h1234_5678, 1'b0, 3, 1'b1);
    drop_req();
    wait_done();

    // stray B and R beats while idle
    @(negedge clk);
    stray_b = 1'b1; stray_r = 1'b1;
    #1;
    check("stray_b_ready", 32'(axi.b_ready), 32'd0);
    check("stray_r_ready", 32'(axi.r_ready), 32'd0);
    repeat (2) @(negedge clk);
    stray_b = 1'b0; stray_r = 1'b0;
    repeat (3) @(negedge clk);

    // 6: reset while ar_valid waits
    ar_delay = 20;
    do_req(1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'h0, 1'b0, 3, 1'b0);
    drop_req();
    check("t6_ar_waiting", 32'(axi.ar_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t6_valids_drop", 32'({axi.aw_valid, axi.w_valid, axi.ar_valid}), 32'd0);
    check("t6_readys_drop", 32'({axi.b_ready, axi.r_ready}), 32'd0);
    check("t6_rvalid", 32'(rvalid_o), 32'd0);
    check("t6_rdata_cleared", rdata_o, 32'd0);
    repeat (2) @(negedge clk);
    ar_delay = 0;
    rst_n = 1'b1;
    rd_val = 32'hCAFE_F00D;
    do_req(1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 1'b0);
    drop_req();
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_core_master.md
# axi_core_master

Single-outstanding AXI4 initiator that converts the core's req/gnt/rvalid data-port handshake into single-beat AXI4 read and write transactions. It drives one `AXI_BUS.Master` port that connects to a slave port of the system crossbar, alongside the instruction-side initiator. It is the initiator-side counterpart of the memory, UART and exit-decoder responders behind the crossbar.

## Interface

**Parameters**
- `AXI_ADDR_WIDTH`, 32: AXI address width. `addr_i` is zero-extended or truncated to this width.
- `AXI_DATA_WIDTH`, 32: AXI data width. Only 32 is supported.
- `AXI_ID_WIDTH`, 16: AXI ID width.
- `AXI_USER_WIDTH`, 10: AXI user width. All user fields are driven to 0.
- `AXI_ID`, 0: constant ID driven on AW and AR.

**Ports**
- `clk_i`  in  1  Single clock.
- `rst_ni`  in  1  Asynchronous, active-low reset.
- `req_i`  in  1  Core request.
- `gnt_o`  out  1  Grant. The request is accepted in the cycle where `req_i && gnt_o`.
- `addr_i`  in  32  Byte address.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  Byte enables; become `w_strb`.
- `wdata_i`  in  32  Write data.
- `rvalid_o`  out  1  One-cycle response pulse.
- `rdata_o`  out  32  Read data; valid while `rvalid_o` is high.
- `err_o`  out  1  Error response; valid while `rvalid_o` is high.
- `AXI_Master`  `AXI_BUS.Master`  Connects to the crossbar slave port.

## Operation

**State machine:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.

**IDLE**
- `gnt_o = req_i` (combinational). No other state grants.
- On accept, register `addr`, `we`, `be` and `wdata`.
- Next state: WR_REQ if `we_i`, otherwise RD_REQ.

**WR_REQ**
- `aw_valid` and `w_valid` both assert on entry.
- Each channel deasserts independently after its own handshake; two pending flags track this.
- Either channel may complete first, or both may complete in the same cycle.
- Leave for WR_RESP in the cycle where the last of the two handshakes occurs.

**WR_RESP**
- `b_ready = 1`.
- On `b_valid`: capture `err = b_resp[1]` (SLVERR or DECERR) and go to IDLE.

**RD_REQ**
- `ar_valid = 1` until `ar_ready`, then go to RD_RESP.

**RD_RESP**
- `r_ready = 1`.
- On `r_valid`: capture `rdata = r_data` and `err = r_resp[1]`, then go to IDLE.
- `r_last` is ignored.

**Response outputs**
- `rvalid_o` is registered: high for exactly the one cycle after the B or R handshake.
- `rdata_o` holds its last read value and is not updated by writes.

**Constant AXI fields**
- `len` = 0, `size` = 3'b010, `burst` = INCR.
- `lock`, `cache`, `prot`, `qos`, `region`, `atop` and `user` = 0.
- `w_last` = 1, `id` = `AXI_ID`.

**Ready outside response states:** `b_ready` and `r_ready` are 0 outside WR_RESP and RD_RESP. Stray B or R beats are therefore never accepted.

**Not checked:** response IDs.

## Timing

**Reset values**
- State = IDLE.
- `aw_valid`, `w_valid`, `ar_valid`, `b_ready`, `r_ready` = 0.
- `rvalid_o` = 0, `rdata_o` = 0, `err_o` = 0.

**Reset mid-transaction:** the transaction is abandoned immediately. Valids drop asynchronously and no response is produced. This is the only permitted deassertion of a valid before its handshake.

**AXI rules**
- A valid, once high, holds until ready. Payload is stable while valid is high.
- Valid never depends combinationally on ready.

**Latency**
- With responders that are always ready and respond in zero cycles: grant in cycle N, request valid in N+1, response handshake in N+2, `rvalid_o` in N+3.
- Each cycle of ready or response stall adds exactly one cycle.

**Back-to-back:** the FSM is in IDLE in the `rvalid_o` cycle. A new request may be granted in the same cycle that `rvalid_o` pulses for the previous one.

**Held request:** `req_i` held high in non-IDLE states gets `gnt_o = 0` until return to IDLE.

## Test plan

1. **Write, always-ready responders.** Write 0x0000_0100, data 0xDEADBEEF, `be` 4'hF, OKAY.
   - AW/W valid in N+1 with `w_strb` 4'hF, `w_last` 1.
   - `rvalid_o` in N+3, `err_o` 0.
2. **Read.** Read 0x0000_0100, responder returns 0xDEADBEEF OKAY.
   - `rvalid_o` in N+3, `rdata_o` 0xDEADBEEF, `err_o` 0.
3. **Channel skew.**
   - Case A: `aw_ready` delayed 3 cycles, `w_ready` immediate. `w_valid` drops after its handshake, `aw_valid` holds until its ready.
   - Case B: the reverse skew.
   - In both cases exactly one B is accepted and the `rvalid_o` pulse is 1 cycle wide.
4. **Error response.** Read 0x3000_0000 returning DECERR (2'b11) → `err_o` 1 with `rvalid_o`. Write returning SLVERR → `err_o` 1.
5. **Back-to-back and stray beats.** `req_i` held high across read then write.
   - Second `gnt_o` coincides with the first `rvalid_o`.
   - A `b_valid` injected while in IDLE sees `b_ready` 0.
6. **Reset mid-transaction.** Assert `rst_ni` low while `ar_valid` is waiting.
   - All valids and readys 0 and `rvalid_o` 0 immediately.
   - After release, a new read completes normally.
